// File: rtl/morse_rate_calibrator_pkg.sv
// Shared definitions for the Morse rate calibrator: default widths,
// calibration state encoding and threshold multipliers.
package morse_rate_calibrator_pkg;

    localparam int CNT_W_DEF     = 16;
    localparam int MIN_DIT_DEF   = 4;
    localparam int CAL_MARKS_DEF = 8;

    // A dah is at least DAH_MULT dits; a word gap is at least WORD_MULT dits.
    // The top computes these as shift-and-add of dit_len.
    localparam int DAH_MULT  = 2;
    localparam int WORD_MULT = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } cal_state_t;

endpackage

// File: rtl/morse_rate_calibrator_mark.sv
// mark_timer: saturating run-length counter for marks (signal == 1) with a
// glitch filter. mark_done pulses combinationally on the edge that samples
// the first 0 after a mark of at least MIN_DIT cycles; mark_len is valid
// while mark_done is high. flush abandons the mark in progress and ignores
// its remaining 1 cycles until a 0 is sampled.
module mark_timer #(
    parameter int CNT_W   = 16,
    parameter int MIN_DIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             signal,
    input  logic             flush,
    output logic             mark_start,
    output logic             mark_done,
    output logic [CNT_W-1:0] mark_len
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_DIT);

    logic [CNT_W-1:0] cnt_reg;
    logic             blocked_reg;

    // Count consecutive mark cycles, saturating; flush clears the count and
    // blocks counting for the rest of an abandoned mark.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg     <= '0;
            blocked_reg <= 1'b0;
        end else if (flush) begin
            cnt_reg     <= '0;
            blocked_reg <= signal;
        end else if (blocked_reg) begin
            cnt_reg <= '0;
            if (!signal) begin
                blocked_reg <= 1'b0;
            end
        end else if (signal) begin
            if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end else begin
            cnt_reg <= '0;
        end
    end

    // First counted cycle of a new mark.
    assign mark_start = signal & ~blocked_reg & ~flush & (cnt_reg == '0);
    // Mark ends on the first sampled 0; short runs are glitches.
    assign mark_done  = ~signal & ~flush & (cnt_reg >= MIN_LEN);
    assign mark_len   = cnt_reg;

endmodule

// File: rtl/morse_rate_calibrator.sv
// Morse rate calibrator: learns the dit length from live traffic, publishes
// dit/dah/word thresholds and tracks slow speed drift once locked.
module morse_rate_calibrator
    import morse_rate_calibrator_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MIN_DIT   = MIN_DIT_DEF,
    parameter int CAL_MARKS = CAL_MARKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             signal,
    input  logic             recal,
    output logic [CNT_W-1:0] dit_len,
    output logic [CNT_W:0]   dah_thresh,
    output logic [CNT_W+2:0] word_thresh,
    output logic             cal_valid,
    output logic             busy
);

    localparam int VW = $clog2(2 * CAL_MARKS + 1);
    localparam logic [VW-1:0]    CAL_LO  = VW'(CAL_MARKS);
    localparam logic [VW-1:0]    CAL_HI  = VW'(2 * CAL_MARKS);
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_DIT);

    cal_state_t       state_reg, state_next;
    logic [CNT_W-1:0] dit_len_reg, dit_len_next;
    logic [CNT_W-1:0] min_reg, min_next;
    logic [CNT_W-1:0] max_reg, max_next;
    logic [VW-1:0]    valid_cnt_reg, valid_cnt_next;

    logic             mark_start;
    logic             mark_done;
    logic [CNT_W-1:0] mark_len;

    mark_timer #(
        .CNT_W   (CNT_W),
        .MIN_DIT (MIN_DIT)
    ) u_mark_timer (
        .clk        (clk),
        .reset      (reset),
        .signal     (signal),
        .flush      (recal),
        .mark_start (mark_start),
        .mark_done  (mark_done),
        .mark_len   (mark_len)
    );

    // Candidate statistics if the current mark is accepted during MEASURE.
    logic             first_mark;
    logic [CNT_W-1:0] min_cand, max_cand;
    logic [VW-1:0]    cnt_inc;
    logic             ratio_ok;

    assign first_mark = (valid_cnt_reg == '0);
    assign min_cand   = (first_mark || mark_len < min_reg) ? mark_len : min_reg;
    assign max_cand   = (first_mark || mark_len > max_reg) ? mark_len : max_reg;
    assign cnt_inc    = valid_cnt_reg + 1'b1;
    assign ratio_ok   = ({1'b0, max_cand} >= {min_cand, 1'b0});

    // Locked-state drift tracking: a 3:1 weighted average toward each dit.
    logic [CNT_W+1:0] adapt_sum;
    logic [CNT_W-1:0] adapt_q;
    logic [CNT_W-1:0] adapt_clamped;
    logic             is_dit;

    assign adapt_sum     = {1'b0, dit_len_reg, 1'b0} + {2'b00, dit_len_reg} + {2'b00, mark_len};
    assign adapt_q       = adapt_sum[CNT_W+1:2];
    assign adapt_clamped = (adapt_q < MIN_LEN) ? MIN_LEN : adapt_q;
    assign is_dit        = ({1'b0, mark_len} < dah_thresh);

    // Calibration state and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            dit_len_reg   <= '0;
            min_reg       <= '0;
            max_reg       <= '0;
            valid_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            dit_len_reg   <= dit_len_next;
            min_reg       <= min_next;
            max_reg       <= max_next;
            valid_cnt_reg <= valid_cnt_next;
        end
    end

    // Next-state logic: collect marks, lock on a clear dit/dah ratio or after
    // enough single-length traffic, then adapt; recal overrides everything.
    always_comb begin
        state_next     = state_reg;
        dit_len_next   = dit_len_reg;
        min_next       = min_reg;
        max_next       = max_reg;
        valid_cnt_next = valid_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (mark_start) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (mark_done) begin
                    min_next       = min_cand;
                    max_next       = max_cand;
                    valid_cnt_next = cnt_inc;
                    if ((cnt_inc >= CAL_LO && ratio_ok) || cnt_inc >= CAL_HI) begin
                        dit_len_next = min_cand;
                        state_next   = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (mark_done && is_dit) begin
                    dit_len_next = adapt_clamped;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (recal) begin
            state_next     = IDLE;
            dit_len_next   = '0;
            min_next       = '0;
            max_next       = '0;
            valid_cnt_next = '0;
        end
    end

    assign dit_len     = dit_len_reg;
    assign dah_thresh  = {dit_len_reg, 1'b0};
    assign word_thresh = {1'b0, dit_len_reg, 2'b00} + {3'b000, dit_len_reg};
    assign cal_valid   = (state_reg == LOCKED);
    assign busy        = (state_reg == MEASURE);

endmodule

// File: doc/morse_rate_calibrator.md
Name: morse_rate_calibrator

Overview:
Measures the incoming raw Morse `signal` and derives the dit unit length in clock cycles, replacing the fixed compile-time dit width.
Publishes `dit_len`, `dah_thresh` and `word_thresh` as runtime configuration for the dit/dah decoder and the letter FSM.
Sits in parallel with the decoder on the same `signal`/`clk`.
Qualifies the whole chain with `cal_valid`.

Parameters:
CNT_W, 16, width of mark counter and dit_len.
MIN_DIT, 4, marks shorter than this (cycles) are glitches and ignored.
CAL_MARKS, 8, valid marks needed before a lock attempt.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
signal  in  1  raw Morse key level (1 = mark), already synchronous to clk.
recal  in  1  one-cycle pulse; discard calibration and restart.
dit_len  out  CNT_W  current dit unit length in cycles.
dah_thresh  out  CNT_W+1  2*dit_len; mark >= this is a dah.
word_thresh  out  CNT_W+3  5*dit_len; space >= this is a word gap.
cal_valid  out  1  1 when dit_len is locked and usable.
busy  out  1  1 in MEASURE state.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; mark counter, min/max, valid-mark count all 0.
- Reset values of outputs: dit_len=0, cal_valid=0, busy=0; dah_thresh and word_thresh therefore 0.
- Mark length = number of consecutive rising edges at which `signal` samples 1.
- Mark counter saturates at 2^CNT_W-1; it never wraps.
- A mark ends on the first edge sampling 0. Its length is evaluated on that edge, so updates are visible the following cycle.
- Marks with length < MIN_DIT are discarded: no state, count, min/max or dit_len change.
- dah_thresh = dit_len<<1 and word_thresh = (dit_len<<2)+dit_len.
  - Both are combinational from the dit_len register, zero-extended, with no overflow.
- States:
  - IDLE:
    - busy=0.
    - First sampled 1 -> MEASURE; that cycle counts as mark cycle 1.
  - MEASURE:
    - busy=1.
    - Each valid mark: min_mark=min(min_mark,len) and max_mark=max(max_mark,len). The first valid mark loads both.
    - Each valid mark also increments valid_cnt.
    - When valid_cnt reaches >= CAL_MARKS and max_mark >= 2*min_mark:
      - dit_len=min_mark, cal_valid=1 -> LOCKED.
    - When valid_cnt reaches 2*CAL_MARKS without the ratio being met:
      - lock anyway with dit_len=min_mark (all-dit or all-dah traffic) -> LOCKED.
  - LOCKED:
    - busy=0, cal_valid=1.
    - Valid mark with len < dah_thresh (dit): dit_len <= (3*dit_len + len)>>2, floor.
      - Intermediate width is CNT_W+2.
      - The result is clamped to a minimum of MIN_DIT.
    - Marks >= dah_thresh do not change dit_len.
- recal pulse, any state:
  - Next cycle: state=IDLE; dit_len, min/max and valid_cnt cleared; cal_valid=0.
  - A mark in progress is abandoned. Its remaining 1 cycles do not count; counting resumes only after a 0 is sampled.
- Simultaneous recal and mark end: recal wins and the mark is dropped.
- reset asserted mid-mark or mid-MEASURE: identical to the power-on reset values above.
- Spaces (0 runs) are not measured; the consumer compares them against the thresholds.

Decomposition:
- Shared package/header `morse_defs.vh`:
  - CNT_W default.
  - MIN_DIT default.
  - State encodings IDLE=2'd0, MEASURE=2'd1, LOCKED=2'd2.
  - Threshold multipliers DAH_MULT=2, WORD_MULT=5.
- One natural sub-module, `mark_timer`:
  - Saturating run-length counter with glitch filter.
  - Emits `mark_done` (1-cycle pulse) and `mark_len`.
  - Has a `flush` input driven by recal.
- The FSM, min/max tracking and adaptation stay in morse_rate_calibrator.

Test Plan:
All runs use MIN_DIT=4 and CAL_MARKS=4 unless stated.
- Marks 10,30,10,30 with 10-cycle spaces -> cycle after 4th mark: dit_len=10, dah_thresh=20, word_thresh=50, cal_valid=1, busy=0.
- Glitch rejection: inject 2-cycle mark between valid ones -> valid_cnt, min_mark and outputs unchanged; lock still occurs after 4th valid mark.
- Locked at dit_len=10, then:
  - mark 14 -> dit_len=11;
  - mark 30 -> dit_len stays 11;
  - mark 4 from dit_len=4 -> stays 4 (clamp).
- All-dit traffic: eight marks of 10 -> no lock after 4th; lock on 8th with dit_len=10.
- recal asserted during 25-cycle mark while LOCKED -> next cycle cal_valid=0, dit_len=0, state IDLE; the rest of that mark is not counted.
- CNT_W=4: a 20-cycle mark -> measured length 15 (saturated); no wrap to 4.
